kb_event_fifo: RTL and testbench

- Sits between kb_driver and memory_map.
- Turns the level-style `ascii` and modifier outputs of kb_driver into discrete key events.
- Generates typematic auto-repeat while a key is held.
- Buffers the events in a first-word-fall-through FIFO that the CPU drains through a memory-mapped read port.
- Replaces ad-hoc repeat logic at the top level.

---
 rtl/kb_event_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_kb_event_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: turns kb_driver's level-style key outputs into discrete key
// events, adds typematic auto-repeat, and queues the events in a
// first-word-fall-through FIFO drained by the CPU through rd_en/rd_data.
//
// Build option: define KB_REPEAT_EN to enable auto-repeat (DELAY/REPEAT
// timing). Without it the repeat state and the timer are not built, and one
// event is produced per distinct nonzero key value.
module kb_event_fifo #(
  parameter int DEPTH        = 16,
  parameter int DELAY_CYCLES = 25000000,
  parameter int RATE_CYCLES  = 12500000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               ascii,
  input  logic                     is_shift,
  input  logic                     is_ctrl,
  input  logic                     is_capital,
  input  logic                     is_special,
  input  logic                     is_error,
  input  logic                     rd_en,
  output logic [15:0]              rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Parameter sanity: FIFO depth must be a power of two >= 2 so the
  // pointers can wrap by plain overflow; repeat intervals must be nonzero.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("kb_event_fifo: DEPTH must be a power of two >= 2");
  end
  if (DELAY_CYCLES < 1 || RATE_CYCLES < 1) begin : g_bad_timing
    $error("kb_event_fifo: DELAY_CYCLES and RATE_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------
  // Event state machine
  // ---------------------------------------------------------------------
`ifdef KB_REPEAT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1
  } state_t;
`endif

  state_t      state_reg, state_next;
  logic [7:0]  key_reg, key_next;
  logic        evt;              // the state machine wants to emit an event
`ifdef KB_REPEAT_EN
  logic [31:0] timer_reg, timer_next;
`endif

  // State, latched key and repeat timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      key_reg   <= 8'h00;
`ifdef KB_REPEAT_EN
      timer_reg <= 32'd0;
`endif
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
`ifdef KB_REPEAT_EN
      timer_reg <= timer_next;
`endif
    end
  end

  // Next-state logic: decide when a key event is emitted.
  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    evt        = 1'b0;
`ifdef KB_REPEAT_EN
    timer_next = timer_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (ascii != 8'h00) begin
          evt        = 1'b1;
          state_next = S_DELAY;
`ifdef KB_REPEAT_EN
          timer_next = 32'd0;
`endif
        end
      end
      S_DELAY: begin
        if (ascii == 8'h00) begin
          state_next = S_IDLE;
        end else if (ascii != key_reg) begin
          // A new key restarts the typematic delay.
          evt = 1'b1;
`ifdef KB_REPEAT_EN
          timer_next = 32'd0;
        end else if (timer_reg == 32'(DELAY_CYCLES - 1)) begin
          evt        = 1'b1;
          timer_next = 32'd0;
          state_next = S_REPEAT;
        end else begin
          timer_next = timer_reg + 32'd1;
`endif
        end
      end
`ifdef KB_REPEAT_EN
      S_REPEAT: begin
        if (ascii == 8'h00) begin
          state_next = S_IDLE;
        end else if (ascii != key_reg) begin
          evt        = 1'b1;
          timer_next = 32'd0;
          state_next = S_DELAY;
        end else if (timer_reg == 32'(RATE_CYCLES - 1)) begin
          evt        = 1'b1;
          timer_next = 32'd0;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // The key is latched on every event, even one whose push is
    // suppressed by is_error, so the state machine tracks the key held.
    if (evt) begin
      key_next = ascii;
    end
  end

  // ---------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  logic [15:0]   push_word;
  logic          push_req;
  logic          full;
  logic          do_push;
  logic          do_pop;
  logic          drop;

  // Push/pop qualification: a pop on an empty FIFO is ignored, and a push
  // into a full FIFO only succeeds when a pop frees the head that cycle.
  always_comb begin
    push_word = {3'b000, is_error, is_special, is_capital, is_ctrl, is_shift, ascii};
    push_req  = evt && !is_error;
    full      = (count_reg == CW'(DEPTH));
    do_pop    = rd_en && (count_reg != '0);
    do_push   = push_req && (!full || do_pop);
    drop      = push_req && full && !do_pop;
  end

  // Entry storage; contents need no reset because rd_data is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // A dropped push in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign rd_data  = empty ? 16'h0000 : mem[rd_ptr_reg];

endmodule

// File: tb/tb_kb_event_fifo.sv
// tb_kb_event_fifo: directed and randomized stimulus for kb_event_fifo with a
// behavioural key-event model feeding a scoreboard queue; a negedge monitor
// compares every popped entry and the FIFO status against the model.
module tb_kb_event_fifo;

  localparam int DEPTH = 4;
  localparam int DLY   = 8;
  localparam int RATE  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    ascii = 8'h00;
  logic          is_shift = 1'b0;
  logic          is_ctrl = 1'b0;
  logic          is_capital = 1'b0;
  logic          is_special = 1'b0;
  logic          is_error = 1'b0;
  logic          rd_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [15:0]   rd_data;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  always #5 clk = ~clk;

  kb_event_fifo #(
    .DEPTH        (DEPTH),
    .DELAY_CYCLES (DLY),
    .RATE_CYCLES  (RATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ascii      (ascii),
    .is_shift   (is_shift),
    .is_ctrl    (is_ctrl),
    .is_capital (is_capital),
    .is_special (is_special),
    .is_error   (is_error),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected entries, occupancy, sticky flag, and the key
  // being held together with the edge index at which it was first seen.
  logic [15:0] q_exp[$];
  int          mdl_count = 0;
  bit          mdl_ovf = 1'b0;
  bit          held = 1'b0;
  logic [7:0]  held_key = 8'h00;
  int          cyc = 0;
  int          t0 = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Does the coming clock edge produce a key event for the current inputs?
  // A new key fires immediately; a held key fires DLY edges later and then
  // every RATE edges.
  function automatic bit predict_evt();
    int e;
    if (ascii == 8'h00) return 1'b0;
    if (!held || ascii != held_key) return 1'b1;
    e = cyc - t0;
`ifdef KB_REPEAT_EN
    return (e == DLY) || (e > DLY && ((e - DLY) % RATE) == 0);
`else
    return (e < 0);
`endif
  endfunction

  task automatic model_reset();
    q_exp.delete();
    mdl_count = 0;
    mdl_ovf   = 1'b0;
    held      = 1'b0;
    cyc       = 0;
    t0        = 0;
  endtask

  // Apply one clock edge's worth of inputs to the model.
  task automatic model_edge();
    bit ev, pop, push, drop;
    if (rst) begin
      model_reset();
      return;
    end
    ev   = predict_evt();
    pop  = rd_en && (mdl_count > 0);
    push = ev && !is_error;
    drop = 1'b0;
    if (ascii == 8'h00) begin
      held = 1'b0;
    end else if (!held || ascii != held_key) begin
      held     = 1'b1;
      held_key = ascii;
      t0       = cyc;
    end
    if (push) begin
      if (mdl_count < DEPTH || pop)
        q_exp.push_back({3'b000, is_error, is_special, is_capital, is_ctrl, is_shift, ascii});
      else
        drop = 1'b1;
    end
    if (push && !drop) mdl_count++;
    if (pop) mdl_count--;
    if (drop) mdl_ovf = 1'b1;
    else if (ovf_clr) mdl_ovf = 1'b0;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // Monitor: status and head word every cycle, one line per popped entry.
  always @(negedge clk) begin
    logic [15:0] head;
    if (mon_en && !rst) begin
      head = (q_exp.size() > 0) ? q_exp[0] : 16'h0000;
      chk("count", 32'(count), 32'(mdl_count));
      chk("empty", 32'(empty), 32'(mdl_count == 0));
      chk("overflow", 32'(overflow), 32'(mdl_ovf));
      chk("rd_data", 32'(rd_data), 32'(head));
      if (rd_en && !empty) begin
        $display("pop %04h count %0d", rd_data, count);
        if (q_exp.size() == 0) begin
          chk("pop_with_model_empty", 32'(q_exp.size()), 32'd1);
        end else begin
          void'(q_exp.pop_front());
        end
      end
    end
  end

  initial begin
    // Power-up reset.
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Single key press with shift.
    ascii = 8'h61; is_shift = 1'b1;
    hold(2);
    ascii = 8'h00; is_shift = 1'b0;
    hold(2);
    chk("single_count", 32'(count), 32'd1);
    chk("single_word", 32'(rd_data), 32'h0161);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("single_drained", 32'(empty), 32'd1);

`ifdef KB_REPEAT_EN
    // Held key: events at edges 0, 8, 12, 16 fill the FIFO.
    ascii = 8'h41;
    hold(20);
    chk("repeat_count", 32'(count), 32'd4);
    chk("repeat_no_ovf", 32'(overflow), 32'd0);
    hold(4);
    chk("repeat_ovf_set", 32'(overflow), 32'd1);
    // Edge 24 drops another repeat while ovf_clr is high: set wins.
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    // Pop exactly on the repeat edges while full: occupancy holds at 4.
    for (int i = 0; i < 12; i++) begin
      rd_en = predict_evt();
      tick();
      rd_en = 1'b0;
      chk("full_push_pop_count", 32'(count), 32'd4);
    end
    chk("full_push_pop_ovf", 32'(overflow), 32'd0);
    ascii = 8'h00;
    rd_en = 1'b1; hold(4); rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
`else
    // Without repeat a long hold gives a single entry.
    ascii = 8'h41;
    hold(40);
    chk("norepeat_count", 32'(count), 32'd1);
    chk("norepeat_word", 32'(rd_data), 32'h0041);
    ascii = 8'h00;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
`endif
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("extra_pop_count", 32'(count), 32'd0);

    // Key change and error suppression.
    ascii = 8'h61; hold(3);
    ascii = 8'h62; hold(3);
    is_error = 1'b1; hold(3);
    ascii = 8'h00; is_error = 1'b0; hold(1);
    chk("change_count", 32'(count), 32'd2);
    chk("change_first", 32'(rd_data), 32'h0061);
    rd_en = 1'b1; tick();
    chk("change_second", 32'(rd_data), 32'h0062);
    tick(); rd_en = 1'b0;
    chk("change_drained", 32'(empty), 32'd1);

    // Asynchronous reset mid-DELAY with three entries queued.
    ascii = 8'h61; hold(2);
    ascii = 8'h62; hold(2);
    ascii = 8'h63; hold(2);
    chk("pre_reset_count", 32'(count), 32'd3);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_reset_empty", 32'(empty), 32'd1);
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_rd_data", 32'(rd_data), 32'd0);
    chk("async_reset_overflow", 32'(overflow), 32'd0);
    ascii = 8'h00;
    tick();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int seg = 0; seg < 80; seg++) begin
      int len;
      case ($urandom_range(0, 4))
        0:       ascii = 8'h61;
        1:       ascii = 8'h62;
        2:       ascii = 8'h41;
        default: ascii = 8'h00;
      endcase
      len = int'($urandom_range(1, 24));
      for (int c = 0; c < len; c++) begin
        is_shift   = ($urandom_range(0, 3) == 0);
        is_ctrl    = ($urandom_range(0, 3) == 0);
        is_capital = ($urandom_range(0, 3) == 0);
        is_special = ($urandom_range(0, 3) == 0);
        is_error   = ($urandom_range(0, 7) == 0);
        rd_en      = ($urandom_range(0, 2) == 0);
        ovf_clr    = ($urandom_range(0, 15) == 0);
        tick();
      end
      if (seg == 40) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end
    end
    rd_en = 1'b0; ovf_clr = 1'b0; is_error = 1'b0; ascii = 8'h00;
    hold(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
